// File: rtl/pwm_pkg.sv
// Shared constants and types for the multichannel PWM peripheral:
// register map offsets, control bit positions, counting mode and direction.
package pwm_pkg;

    localparam int ADDR_EN_OUT    = 'h00;
    localparam int ADDR_EN_PWM    = 'h08;
    localparam int ADDR_INV       = 'h10;
    localparam int ADDR_PRESC     = 'h18;
    localparam int ADDR_CTRL      = 'h19;
    localparam int ADDR_DUTY_BASE = 'h40;

    localparam int CTRL_MODE_BIT  = 0;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: clock prescaler, period counter (edge or center
// aligned) and the update strobe that marks the start of each period.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] i_presc,
    input  pwm_mode_e          i_mode,
    input  logic               i_modeWrite,
    output logic [CNT_W-1:0]   o_cnt,
    output logic               o_strobe
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PRESC_W-1:0] r_prescCnt;
    logic [CNT_W-1:0]   r_cnt;
    pwm_dir_e           r_dir;
    logic               r_primed;

    logic [PRESC_W-1:0] w_prescNext;
    logic [CNT_W-1:0]   w_cntNext;
    pwm_dir_e           w_dirNext;
    logic               w_primedNext;
    logic               w_tick;
    logic               w_strobe;

    assign o_cnt    = r_cnt;
    assign o_strobe = w_strobe;

    // Timebase state register; r_primed stays low after reset so the first tick reloads duties while the count holds at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescCnt <= '0;
            r_cnt      <= '0;
            r_dir      <= DIR_UP;
            r_primed   <= 1'b0;
        end else begin
            r_prescCnt <= w_prescNext;
            r_cnt      <= w_cntNext;
            r_dir      <= w_dirNext;
            r_primed   <= w_primedNext;
        end
    end

    // Next-state logic: prescaler wrap, counter stepping per mode, and strobe whenever the count enters 0 or the mode is rewritten.
    always_comb begin
        w_prescNext  = r_prescCnt;
        w_cntNext    = r_cnt;
        w_dirNext    = r_dir;
        w_primedNext = r_primed;
        w_strobe     = 1'b0;
        w_tick       = (r_prescCnt == i_presc);

        if (i_modeWrite) begin
            w_prescNext  = '0;
            w_cntNext    = '0;
            w_dirNext    = DIR_UP;
            w_primedNext = 1'b1;
            w_strobe     = 1'b1;
        end else begin
            if (r_prescCnt >= i_presc) begin
                w_prescNext = '0;
            end else begin
                w_prescNext = r_prescCnt + 1'b1;
            end

            if (w_tick) begin
                if (!r_primed) begin
                    w_primedNext = 1'b1;
                    w_cntNext    = '0;
                    w_dirNext    = DIR_UP;
                    w_strobe     = 1'b1;
                end else if (i_mode == MODE_EDGE) begin
                    w_cntNext = r_cnt + 1'b1;
                    w_dirNext = DIR_UP;
                    w_strobe  = (r_cnt == CNT_MAX);
                end else begin
                    case (r_dir)
                        DIR_UP: begin
                            if (r_cnt == CNT_MAX) begin
                                w_cntNext = CNT_MAX - 1'b1;
                                w_dirNext = DIR_DOWN;
                            end else begin
                                w_cntNext = r_cnt + 1'b1;
                            end
                        end
                        DIR_DOWN: begin
                            if (r_cnt <= CNT_W'(1)) begin
                                w_cntNext = '0;
                                w_dirNext = DIR_UP;
                                w_strobe  = 1'b1;
                            end else begin
                                w_cntNext = r_cnt - 1'b1;
                            end
                        end
                        default: begin
                            w_cntNext = '0;
                            w_dirNext = DIR_UP;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM peripheral: byte-wide register file, double-buffered
// per-channel duty, and registered output mux driven by a shared timebase.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam int NUM_BYTES = NUM_CH / 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0]  r_enOut;
    logic [NUM_CH-1:0]  r_enPwm;
    logic [NUM_CH-1:0]  r_invert;
    logic [PRESC_W-1:0] r_presc;
    pwm_mode_e          r_mode;
    logic [CNT_W-1:0]   r_dutyShadow [NUM_CH];
    logic [CNT_W-1:0]   r_dutyActive [NUM_CH];
    logic [NUM_CH-1:0]  r_pwmOut;
    logic               r_periodStart;
    logic [7:0]         r_rdData;

    logic               w_modeWrite;
    logic               w_strobe;
    logic [CNT_W-1:0]   w_cnt;
    logic [NUM_CH-1:0]  w_raw;
    logic [NUM_CH-1:0]  w_pwmNext;
    logic [7:0]         w_rdNext;

    assign w_modeWrite  = wr_en && (wr_addr == ADDR_W'(ADDR_CTRL));
    assign pwm_out      = r_pwmOut;
    assign period_start = r_periodStart;
    assign rd_data      = r_rdData;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .i_presc     (r_presc),
        .i_mode      (r_mode),
        .i_modeWrite (w_modeWrite),
        .o_cnt       (w_cnt),
        .o_strobe    (w_strobe)
    );

    // Register file writes; addresses outside the populated bytes and channels simply match nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enOut  <= '0;
            r_enPwm  <= '0;
            r_invert <= '0;
            r_presc  <= '0;
            r_mode   <= MODE_EDGE;
            for (int i = 0; i < NUM_CH; i++) begin
                r_dutyShadow[i] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (wr_addr == ADDR_W'(ADDR_EN_OUT + k)) r_enOut[8*k +: 8]  <= wr_data;
                if (wr_addr == ADDR_W'(ADDR_EN_PWM + k)) r_enPwm[8*k +: 8]  <= wr_data;
                if (wr_addr == ADDR_W'(ADDR_INV + k))    r_invert[8*k +: 8] <= wr_data;
            end
            if (wr_addr == ADDR_W'(ADDR_PRESC)) r_presc <= wr_data[PRESC_W-1:0];
            if (wr_addr == ADDR_W'(ADDR_CTRL))  r_mode  <= pwm_mode_e'(wr_data[CTRL_MODE_BIT]);
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == ADDR_W'(ADDR_DUTY_BASE + i)) r_dutyShadow[i] <= wr_data[CNT_W-1:0];
            end
        end
    end

    // Active duties reload from the shadows only on the strobe edge, so a shadow written in that same cycle waits a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_dutyActive[i] <= '0;
            end
            r_periodStart <= 1'b0;
            r_pwmOut      <= '0;
            r_rdData      <= '0;
        end else begin
            if (w_strobe) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_dutyActive[i] <= r_dutyShadow[i];
                end
            end
            r_periodStart <= w_strobe;
            r_pwmOut      <= w_pwmNext;
            r_rdData      <= w_rdNext;
        end
    end

    // Per-channel compare and enable/invert mux; full-scale duty is forced high so it never drops for one count.
    always_comb begin
        w_raw     = '0;
        w_pwmNext = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_raw[i]     = (r_dutyActive[i] == CNT_MAX) ? 1'b1 : (w_cnt < r_dutyActive[i]);
            w_pwmNext[i] = r_enOut[i] & (r_enPwm[i] ? (w_raw[i] ^ r_invert[i]) : ~r_invert[i]);
        end
    end

    // Readback mux sampling current register contents, so a same-cycle write is not yet visible.
    always_comb begin
        w_rdNext = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (rd_addr == ADDR_W'(ADDR_EN_OUT + k)) w_rdNext = r_enOut[8*k +: 8];
            if (rd_addr == ADDR_W'(ADDR_EN_PWM + k)) w_rdNext = r_enPwm[8*k +: 8];
            if (rd_addr == ADDR_W'(ADDR_INV + k))    w_rdNext = r_invert[8*k +: 8];
        end
        if (rd_addr == ADDR_W'(ADDR_PRESC)) w_rdNext = 8'(r_presc);
        if (rd_addr == ADDR_W'(ADDR_CTRL))  w_rdNext = {7'b0, r_mode};
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == ADDR_W'(ADDR_DUTY_BASE + i)) w_rdNext = 8'(r_dutyShadow[i]);
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed testbench for pwm_multichannel: register access, enable/invert
// mux, edge and center PWM timing, duty double-buffering and reset recovery.
module tb_pwm_multichannel;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [15:0] pwm_out;
    logic        period_start;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    pwm_multichannel #(
        .NUM_CH  (16),
        .CNT_W   (8),
        .PRESC_W (8),
        .ADDR_W  (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic readReg(input logic [6:0] addr, output logic [7:0] data);
        rd_addr = addr;
        tick(1);
        data = rd_data;
    endtask

    task automatic waitStrobe();
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (!period_start && n < 3000);
        if (!period_start) checkOutput("strobe_timeout", 32'd0, 32'd1);
    endtask

    // Starts on a period_start sample, ends on the next one; optionally writes a register at sample writeAt.
    task automatic measure(input int ch, input int writeAt, input logic [6:0] addr, input logic [7:0] data,
                           output int high, output int period, output int runAfter);
        bit inRun = 1'b1;
        high     = 0;
        period   = 0;
        runAfter = 0;
        do begin
            if (pwm_out[ch]) high++;
            if (period >= 1) begin
                if (inRun && pwm_out[ch]) runAfter++;
                else inRun = 1'b0;
            end
            if (period == writeAt) begin
                wr_en   = 1'b1;
                wr_addr = addr;
                wr_data = data;
            end
            tick(1);
            wr_en = 1'b0;
            period++;
        end while (!period_start && period < 3000);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] d;
        int high, period, runAfter;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        tick(3);
        checkOutput("reset_pwm_out", pwm_out, 32'h0);
        checkOutput("reset_period_start", period_start, 32'h0);
        checkOutput("reset_rd_data", rd_data, 32'h0);
        rst = 1'b0;
        tick(1);
        checkOutput("first_strobe_after_reset", period_start, 32'h1);

        // Static enables
        applyStimulus(7'h00, 8'hFF);
        checkOutput("en_out_one_cycle", pwm_out, 32'h0);
        tick(1);
        checkOutput("en_out_two_cycles", pwm_out, 32'h00FF);
        readReg(7'h00, d); checkOutput("read_en_out0", d, 32'hFF);
        readReg(7'h01, d); checkOutput("read_en_out1", d, 32'h00);

        // Unmapped byte and channel writes are dropped
        applyStimulus(7'h02, 8'hFF);
        readReg(7'h02, d); checkOutput("read_unmapped_byte", d, 32'h00);
        applyStimulus(7'h50, 8'h55);
        readReg(7'h50, d); checkOutput("read_unmapped_duty", d, 32'h00);
        checkOutput("pwm_after_unmapped", pwm_out, 32'h00FF);

        // Invert handling
        applyStimulus(7'h10, 8'h01);
        applyStimulus(7'h00, 8'hFE);
        tick(1);
        checkOutput("inv_en_out_off", pwm_out, 32'h00FE);
        applyStimulus(7'h00, 8'hFF);
        tick(1);
        checkOutput("inv_static_level", pwm_out, 32'h00FE);
        readReg(7'h10, d); checkOutput("read_invert", d, 32'h01);
        applyStimulus(7'h10, 8'h00);
        tick(1);
        checkOutput("inv_cleared", pwm_out, 32'h00FF);

        // Same-cycle write and read returns the old value
        rd_addr = 7'h08; wr_en = 1'b1; wr_addr = 7'h08; wr_data = 8'h01;
        tick(1);
        wr_en = 1'b0;
        checkOutput("rw_same_addr_old", rd_data, 32'h00);
        tick(1);
        checkOutput("rw_same_addr_new", rd_data, 32'h01);

        // Edge mode, P=0, duty 0x40
        applyStimulus(7'h40, 8'h40);
        readReg(7'h40, d); checkOutput("read_duty0", d, 32'h40);
        waitStrobe(); waitStrobe();
        measure(0, -1, 7'h0, 8'h0, high, period, runAfter);
        checkOutput("edge_high", high, 32'd64);
        checkOutput("edge_period", period, 32'd256);
        checkOutput("edge_run_after_strobe", runAfter, 32'd64);

        // Shadow write mid-period and in the strobe cycle
        measure(0, 100, 7'h40, 8'h20, high, period, runAfter);
        checkOutput("mid_write_old_wave", high, 32'd64);
        measure(0, -1, 7'h0, 8'h0, high, period, runAfter);
        checkOutput("mid_write_next_period", high, 32'd32);
        measure(0, 255, 7'h40, 8'h10, high, period, runAfter);
        checkOutput("strobe_write_cur", high, 32'd32);
        measure(0, -1, 7'h0, 8'h0, high, period, runAfter);
        checkOutput("strobe_write_not_captured", high, 32'd32);
        measure(0, -1, 7'h0, 8'h0, high, period, runAfter);
        checkOutput("strobe_write_applied", high, 32'd16);

        // Full-scale and zero duty
        applyStimulus(7'h40, 8'hFF);
        waitStrobe(); waitStrobe();
        measure(0, -1, 7'h0, 8'h0, high, period, runAfter);
        checkOutput("duty_full", high, 32'd256);
        applyStimulus(7'h40, 8'h00);
        waitStrobe(); waitStrobe();
        measure(0, -1, 7'h0, 8'h0, high, period, runAfter);
        checkOutput("duty_zero", high, 32'd0);

        // Center mode, P=1, ch3 duty 0x80
        applyStimulus(7'h08, 8'h09);
        applyStimulus(7'h43, 8'h80);
        applyStimulus(7'h18, 8'h01);
        applyStimulus(7'h19, 8'h01);
        checkOutput("mode_write_forced_strobe", period_start, 32'h1);
        readReg(7'h19, d); checkOutput("read_ctrl", d, 32'h01);
        readReg(7'h18, d); checkOutput("read_presc", d, 32'h01);
        waitStrobe();
        measure(3, -1, 7'h0, 8'h0, high, period, runAfter);
        checkOutput("center_period", period, 32'd1020);
        checkOutput("center_high", high, 32'd510);
        checkOutput("center_run_after_strobe", runAfter, 32'd256);

        // Reset mid-pulse
        tick(10);
        checkOutput("pulse_high_before_reset", pwm_out[3], 32'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("midreset_pwm_out", pwm_out, 32'h0);
        checkOutput("midreset_period_start", period_start, 32'h0);
        checkOutput("midreset_rd_data", rd_data, 32'h0);
        tick(1);
        checkOutput("restart_strobe", period_start, 32'h1);
        checkOutput("restart_pwm_out", pwm_out, 32'h0);
        readReg(7'h00, d); checkOutput("rst_read_en_out", d, 32'h00);
        readReg(7'h08, d); checkOutput("rst_read_en_pwm", d, 32'h00);
        readReg(7'h43, d); checkOutput("rst_read_duty3", d, 32'h00);
        readReg(7'h18, d); checkOutput("rst_read_presc", d, 32'h00);
        readReg(7'h19, d); checkOutput("rst_read_ctrl", d, 32'h00);
        applyStimulus(7'h7F, 8'hAA);
        readReg(7'h7F, d); checkOutput("read_0x7f", d, 32'h00);

        // Counting resumes in edge mode from defaults
        applyStimulus(7'h00, 8'h01);
        applyStimulus(7'h08, 8'h01);
        applyStimulus(7'h40, 8'h40);
        waitStrobe(); waitStrobe();
        measure(0, -1, 7'h0, 8'h0, high, period, runAfter);
        checkOutput("post_reset_high", high, 32'd64);
        checkOutput("post_reset_period", period, 32'd256);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
